action_dispatch: RTL and testbench
==================================

ACTION_DISPATCH -- requirements
Module: action_dispatch

Interface
REQ-001 SHALL have parameter COLS, default 8, board columns (2..16).
REQ-002 SHALL have parameter ROWS, default 8, board rows (2..16).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port action  input  3  action code from clicker: 000 none, 001 single btnC, 010 double btnC, 100 U, 101 R, 110 D, 111 L.
REQ-006 SHALL have port busy  input  1  board engine cannot accept a reveal/flag request this cycle.
REQ-007 SHALL have port ack  output  1  acknowledge back to clicker; clears its held code.
REQ-008 SHALL have port cursor_x  output  4  cursor column, 0..COLS-1.
REQ-009 SHALL have port cursor_y  output  4  cursor row, 0..ROWS-1.
REQ-010 SHALL have port reveal_req  output  1  one-cycle pulse: reveal the cell at cursor.
REQ-011 SHALL have port flag_req  output  1  one-cycle pulse: toggle flag at cursor.
REQ-012 SHALL have port action_cnt  output  8  count of executed reveal/flag requests, saturating at 255.

Function
REQ-013 SHALL implement FSM states IDLE, DISPATCH, ISSUE, ACK.
REQ-014 SHALL, in IDLE with action != 000, latch action into an internal code register and go to DISPATCH next cycle.
REQ-015 SHALL ignore action while not in IDLE; only the latched code is acted on.
REQ-016 SHALL, in DISPATCH with code 100, decrement cursor_y, wrapping 0 -> ROWS-1; go to ACK.
REQ-017 SHALL, in DISPATCH with code 110, increment cursor_y, wrapping ROWS-1 -> 0; go to ACK.
REQ-018 SHALL, in DISPATCH with code 111, decrement cursor_x, wrapping 0 -> COLS-1; go to ACK.
REQ-019 SHALL, in DISPATCH with code 101, increment cursor_x, wrapping COLS-1 -> 0; go to ACK.
REQ-020 SHALL, in DISPATCH with code 001 or 010, go to ISSUE.
REQ-021 SHALL, in DISPATCH with code 011, make no change and go to ACK.
REQ-022 SHALL, in ISSUE with busy=1, hold state with reveal_req and flag_req low.
REQ-023 SHALL, in ISSUE with busy=0, pulse reveal_req (code 001) or flag_req (code 010) for exactly one cycle; go to ACK.
REQ-024 SHALL increment action_cnt by 1 on each reveal/flag pulse; hold at 255.
REQ-025 SHALL assert ack, registered, in every cycle the FSM is in ACK; ack low elsewhere.
REQ-026 SHALL leave ACK for IDLE the first cycle action == 000 is sampled while in ACK; a held nonzero action keeps ack asserted.
REQ-027 SHALL, for a move code, hold the updated cursor at the ack rising edge; reveal/flag pulse precedes ack rising by exactly one cycle.
REQ-028 SHALL give minimum latency: action nonzero at edge k -> move applied or request pulsed after edge k+1 (ISSUE adds >= 1 cycle) -> ack high after edge k+2 for moves, k+3 for requests with busy=0.
REQ-029 SHALL never assert reveal_req and flag_req together.

Reset
REQ-030 SHALL, when clear=1 at a rising edge, force state IDLE, code 000, ack 0, reveal_req 0, flag_req 0, cursor_x 0, cursor_y 0, action_cnt 0.
REQ-031 SHALL give clear priority over every transition, including mid-ISSUE with busy=1 and mid-ACK; no pending request survives.

Structure
REQ-032 SHALL take action codes (OP_NONE 000, OP_BTNC 001, OP_DBLBTNC 010, OP_U/R/D/L 100-111) from the shared codebase constants file, not local literals.
REQ-033 SHALL place FSM state encodings in the same shared constants file.
REQ-034 SHALL use one sub-module, wrap_counter (parameterised modulus, inc/dec enables, synchronous clear), instantiated for cursor_x and cursor_y.

Verification
REQ-035 SHALL cover: clear, then action=101 held until ack -> cursor_x 0->1, ack high 2 cycles after action, ack drops 1 cycle after action=000.
REQ-036 SHALL cover: cursor_x=0, action=111 -> cursor_x=COLS-1 (7); cursor_y=7, action=110 -> cursor_y=0.
REQ-037 SHALL cover: busy=1 for 5 cycles, action=001 -> no reveal_req while busy; one reveal_req pulse the cycle after busy falls; ack next cycle; action_cnt=1.
REQ-038 SHALL cover: action=010 changing to 100 while in ISSUE -> only flag_req pulses, cursor unchanged.
REQ-039 SHALL cover: clear asserted during ISSUE with busy=1 -> next cycle all outputs at reset values; no request after busy drops.
REQ-040 SHALL cover: 260 reveal actions -> action_cnt saturates at 255.

Source files
------------

// File: rtl/action_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// action_dispatch_pkg
// Shared constants for the board-control slice:
//   - action codes produced by the clicker front end
//   - FSM state encodings of the action dispatcher
//   - request-counter ceiling and small decode helpers
// ---------------------------------------------------------------------------
package action_dispatch_pkg;

    // Action codes from the clicker.
    localparam logic [2:0] OP_NONE    = 3'b000;
    localparam logic [2:0] OP_BTNC    = 3'b001;
    localparam logic [2:0] OP_DBLBTNC = 3'b010;
    localparam logic [2:0] OP_NOP     = 3'b011;
    localparam logic [2:0] OP_U       = 3'b100;
    localparam logic [2:0] OP_R       = 3'b101;
    localparam logic [2:0] OP_D       = 3'b110;
    localparam logic [2:0] OP_L       = 3'b111;

    // Dispatcher FSM states.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPATCH = 2'd1;
    localparam logic [1:0] ST_ISSUE    = 2'd2;
    localparam logic [1:0] ST_ACK      = 2'd3;

    // Ceiling of the executed-request counter.
    localparam logic [7:0] CNT_MAX = 8'd255;

    // Cursor moves all live in the upper half of the code space.
    function automatic logic isMove(input logic [2:0] op);
        return op[2];
    endfunction

    // Reveal and flag are the only codes that talk to the board engine.
    function automatic logic isRequest(input logic [2:0] op);
        return (op == OP_BTNC) || (op == OP_DBLBTNC);
    endfunction

endpackage

// File: rtl/action_dispatch_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Modulo-MODULUS up/down counter used for one cursor axis.
//   clk    : system clock
//   clear  : synchronous active-high clear to 0
//   inc    : step up, MODULUS-1 wraps to 0
//   dec    : step down, 0 wraps to MODULUS-1
//   value  : current count, 0..MODULUS-1
// inc and dec together cancel out (no change).
// ---------------------------------------------------------------------------
module wrap_counter #(
    parameter int MODULUS = 8,
    parameter int W       = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] TOP = W'(MODULUS - 1);

    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (inc && !dec) begin
            value <= (value == TOP) ? '0 : value + 1'b1;
        end else if (dec && !inc) begin
            value <= (value == '0) ? TOP : value - 1'b1;
        end
    end

endmodule

// File: rtl/action_dispatch.sv
// ---------------------------------------------------------------------------
// action_dispatch
// Turns held clicker action codes into cursor moves or one-cycle
// reveal/flag requests to the board engine, then handshakes with ack.
//   clk        : system clock, rising edge
//   clear      : synchronous active-high reset
//   action     : held action code from the clicker (0 = none)
//   busy       : board engine cannot take a request this cycle
//   ack        : registered acknowledge, clicker drops its code on it
//   cursor_x   : cursor column 0..COLS-1
//   cursor_y   : cursor row 0..ROWS-1
//   reveal_req : one-cycle pulse, reveal cell under cursor
//   flag_req   : one-cycle pulse, toggle flag under cursor
//   action_cnt : executed reveal/flag requests, saturating at 255
// ---------------------------------------------------------------------------
module action_dispatch
    import action_dispatch_pkg::*;
#(
    parameter int COLS = 8,
    parameter int ROWS = 8
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [2:0] action,
    input  logic       busy,
    output logic       ack,
    output logic [3:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       reveal_req,
    output logic       flag_req,
    output logic [7:0] action_cnt
);

    logic [1:0] state;
    logic [1:0] nextState;
    logic [2:0] code;

    logic incX;
    logic decX;
    logic incY;
    logic decY;
    logic issueNow;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

    // Next-state logic. Only the latched code steers DISPATCH/ISSUE;
    // the live action input matters only in IDLE and ACK.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (action != OP_NONE) nextState = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                if (isRequest(code))   nextState = ST_ISSUE;
                else if (isMove(code)) nextState = ST_ACK;
                else                   nextState = ST_ACK;
            end
            ST_ISSUE: begin
                if (!busy) nextState = ST_ACK;
            end
            ST_ACK: begin
                if (action == OP_NONE) nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Cursor steps happen on the single DISPATCH cycle of a move.
    always_comb begin
        incX = (state == ST_DISPATCH) && (code == OP_R);
        decX = (state == ST_DISPATCH) && (code == OP_L);
        incY = (state == ST_DISPATCH) && (code == OP_D);
        decY = (state == ST_DISPATCH) && (code == OP_U);
        issueNow = (state == ST_ISSUE) && !busy;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= ST_IDLE;
            code       <= OP_NONE;
            ack        <= 1'b0;
            reveal_req <= 1'b0;
            flag_req   <= 1'b0;
            action_cnt <= '0;
        end else begin
            state <= nextState;
            if (state == ST_IDLE && action != OP_NONE) begin
                code <= action;
            end
            // Pulses are mutually exclusive because code holds one value.
            reveal_req <= issueNow && (code == OP_BTNC);
            flag_req   <= issueNow && (code == OP_DBLBTNC);
            if (issueNow) begin
                action_cnt <= satInc(action_cnt);
            end
            // ack rises one cycle after entering ACK, so it trails the
            // cursor update / request pulse by a cycle, and it falls on
            // the same edge that returns the FSM to IDLE.
            ack <= (state == ST_ACK) && (action != OP_NONE);
        end
    end

    wrap_counter #(.MODULUS(COLS), .W(4)) uColCounter (
        .clk   (clk),
        .clear (clear),
        .inc   (incX),
        .dec   (decX),
        .value (cursor_x)
    );

    wrap_counter #(.MODULUS(ROWS), .W(4)) uRowCounter (
        .clk   (clk),
        .clear (clear),
        .inc   (incY),
        .dec   (decY),
        .value (cursor_y)
    );

endmodule

// File: tb/tb_action_dispatch.sv
// ---------------------------------------------------------------------------
// tb_action_dispatch
// Directed bench for action_dispatch (COLS=8, ROWS=8). Inputs change 1 time
// unit after a rising edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_action_dispatch;

    logic       clk;
    logic       clear;
    logic [2:0] action;
    logic       busy;
    logic       ack;
    logic [3:0] cursor_x;
    logic [3:0] cursor_y;
    logic       reveal_req;
    logic       flag_req;
    logic [7:0] action_cnt;

    int total = 0;
    int bad   = 0;
    int reqSeen;

    action_dispatch #(.COLS(8), .ROWS(8)) dut (
        .clk        (clk),
        .clear      (clear),
        .action     (action),
        .busy       (busy),
        .ack        (ack),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .reveal_req (reveal_req),
        .flag_req   (flag_req),
        .action_cnt (action_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Move: latch, apply, ack, then release and see ack drop.
    task automatic doMove(input logic [2:0] op, input string tag);
        action = op;
        step(3);
        chk({tag, "_ack_hi"}, ack, 1);
        action = 3'b000;
        step(1);
        chk({tag, "_ack_lo"}, ack, 0);
    endtask

    // Exclusivity of the two request pulses, checked every cycle.
    always @(negedge clk) begin
        if (reveal_req && flag_req) chk("req_exclusive", 1, 0);
    end

    initial begin
        clear  = 1'b1;
        action = 3'b000;
        busy   = 1'b0;
        step(2);

        // Reset state
        chk("rst_ack", ack, 0);
        chk("rst_cx", cursor_x, 0);
        chk("rst_cy", cursor_y, 0);
        chk("rst_rr", reveal_req, 0);
        chk("rst_fr", flag_req, 0);
        chk("rst_cnt", action_cnt, 0);
        clear = 1'b0;
        step(1);

        // Move right with timing: ack 2 edges after the sampling edge
        action = 3'b101;
        step(1);
        chk("r_e0_cx", cursor_x, 0);
        chk("r_e0_ack", ack, 0);
        step(1);
        chk("r_e1_cx", cursor_x, 1);
        chk("r_e1_ack", ack, 0);
        step(1);
        chk("r_e2_ack", ack, 1);
        chk("r_e2_cx", cursor_x, 1);
        step(1);
        chk("r_hold_ack", ack, 1);
        action = 3'b000;
        step(1);
        chk("r_drop_ack", ack, 0);

        // Wrap boundaries
        doMove(3'b111, "l1");
        chk("l1_cx", cursor_x, 0);
        doMove(3'b111, "lwrap");
        chk("lwrap_cx", cursor_x, 7);
        doMove(3'b101, "rwrap");
        chk("rwrap_cx", cursor_x, 0);
        doMove(3'b100, "uwrap");
        chk("uwrap_cy", cursor_y, 7);
        doMove(3'b110, "dwrap");
        chk("dwrap_cy", cursor_y, 0);

        // Code 011 does nothing but still acknowledges
        doMove(3'b011, "nop");
        chk("nop_cx", cursor_x, 0);
        chk("nop_cy", cursor_y, 0);
        chk("nop_cnt", action_cnt, 0);

        // Reveal while the engine is busy for 5 cycles
        busy   = 1'b1;
        action = 3'b001;
        step(2);
        for (int i = 0; i < 3; i++) begin
            chk("busy_no_rr", reveal_req, 0);
            step(1);
        end
        chk("busy_no_rr_last", reveal_req, 0);
        busy = 1'b0;
        step(1);
        chk("rv_rr", reveal_req, 1);
        chk("rv_fr", flag_req, 0);
        chk("rv_ack_pre", ack, 0);
        chk("rv_cnt", action_cnt, 1);
        step(1);
        chk("rv_rr_off", reveal_req, 0);
        chk("rv_ack", ack, 1);
        action = 3'b000;
        step(1);
        chk("rv_ack_lo", ack, 0);

        // Flag with the action changing to a move during ISSUE
        action = 3'b010;
        step(2);
        action = 3'b100;
        step(1);
        chk("fl_fr", flag_req, 1);
        chk("fl_rr", reveal_req, 0);
        chk("fl_cnt", action_cnt, 2);
        step(1);
        chk("fl_fr_off", flag_req, 0);
        chk("fl_ack", ack, 1);
        chk("fl_cy", cursor_y, 0);
        action = 3'b000;
        step(2);
        chk("fl_cy_after", cursor_y, 0);
        chk("fl_cx_after", cursor_x, 0);

        // Clear in ISSUE with busy high, cursor moved away from 0 first
        doMove(3'b101, "pre1");
        doMove(3'b110, "pre2");
        chk("pre_cx", cursor_x, 1);
        chk("pre_cy", cursor_y, 1);
        busy   = 1'b1;
        action = 3'b001;
        step(3);
        clear = 1'b1;
        step(1);
        chk("clr_ack", ack, 0);
        chk("clr_cx", cursor_x, 0);
        chk("clr_cy", cursor_y, 0);
        chk("clr_rr", reveal_req, 0);
        chk("clr_fr", flag_req, 0);
        chk("clr_cnt", action_cnt, 0);
        clear  = 1'b0;
        action = 3'b000;
        busy   = 1'b0;
        reqSeen = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (reveal_req || flag_req || ack) reqSeen++;
        end
        chk("clr_no_req", reqSeen, 0);

        // 260 reveals: counter saturates at 255
        for (int i = 0; i < 260; i++) begin
            action = 3'b001;
            step(4);
            action = 3'b000;
            step(1);
            if (i == 0)   chk("sat_first", action_cnt, 1);
            if (i == 253) chk("sat_254", action_cnt, 254);
            if (i == 254) chk("sat_255", action_cnt, 255);
        end
        chk("sat_final", action_cnt, 255);
        chk("sat_ack", ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
